// File: rtl/sym_vn_lut_load_ctrl_pkg.sv
// Shared widths, timing constants and FSM state type for the symmetric VN LUT reload controller.
package sym_vn_lut_load_ctrl_pkg;
  localparam int unsigned QUAN_SIZE   = 4;
  localparam int unsigned PAGE_ADDR_W = 6;
  localparam int unsigned PAGE_NUM    = 2 ** PAGE_ADDR_W;
  localparam int unsigned ENTRY_CNT_W = PAGE_ADDR_W + 1;
  localparam int unsigned DRAIN_CYC   = 2;
  localparam int unsigned DRAIN_W     = $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ARMED = 2'd2,
    DRAIN = 2'd3
  } ld_state_e;
endpackage

// File: rtl/sym_vn_lut_load_ctrl_if.sv
// Entry stream plus LUT page-write port; master is the reload controller, slave is the peer side.
interface sym_vn_lut_load_ctrl_if;
  import sym_vn_lut_load_ctrl_pkg::*;

  logic [QUAN_SIZE-1:0]   in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [QUAN_SIZE-1:0]   lut_in_bank0;
  logic [QUAN_SIZE-1:0]   lut_in_bank1;
  logic [PAGE_ADDR_W-1:0] page_write_addr;
  logic                   write_addr_offset;
  logic                   we;

  modport master (
    input  in_data, in_valid,
    output in_ready, lut_in_bank0, lut_in_bank1, page_write_addr, write_addr_offset, we
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, lut_in_bank0, lut_in_bank1, page_write_addr, write_addr_offset, we
  );
endinterface

// File: rtl/sym_vn_lut_pack.sv
// Pairs even/odd LUT entries into one page write {bank1,bank0}; the write issues the cycle after the odd entry.
module sym_vn_lut_pack
  import sym_vn_lut_load_ctrl_pkg::*;
(
  input  logic                   write_clk,
  input  logic                   rstn,
  input  logic                   clear,
  input  logic                   in_ready,
  input  logic                   in_valid,
  input  logic [QUAN_SIZE-1:0]   in_data,
  output logic                   we,
  output logic [PAGE_ADDR_W-1:0] page_write_addr,
  output logic [QUAN_SIZE-1:0]   lut_in_bank0,
  output logic [QUAN_SIZE-1:0]   lut_in_bank1,
  output logic                   last_accept
);
  logic [ENTRY_CNT_W-1:0] k;
  logic [QUAN_SIZE-1:0]   held;
  logic                   accept;

  assign accept      = in_valid & in_ready;
  assign last_accept = accept & (k == '1);

  always_ff @(posedge write_clk) begin
    if (!rstn) begin
      k               <= '0;
      held            <= '0;
      we              <= 1'b0;
      page_write_addr <= '0;
      lut_in_bank0    <= '0;
      lut_in_bank1    <= '0;
    end else begin
      we <= 1'b0;
      if (clear) begin
        k <= '0;
      end else if (accept) begin
        k <= k + ENTRY_CNT_W'(1);
        if (!k[0]) begin
          held <= in_data;
        end else begin
          we              <= 1'b1;
          page_write_addr <= k[ENTRY_CNT_W-1:1];
          lut_in_bank0    <= held;
          lut_in_bank1    <= in_data;
        end
      end
    end
  end
endmodule

// File: rtl/sym_vn_lut_load_ctrl.sv
// Double-buffered reload sequencer for the symmetric VN LUT: load shadow set, swap at iteration boundary, drain.
module sym_vn_lut_load_ctrl
  import sym_vn_lut_load_ctrl_pkg::*;
(
  input  logic                          write_clk,
  input  logic                          rstn,
  input  logic                          load_start,
  input  logic                          iter_boundary,
  sym_vn_lut_load_ctrl_if.master        bus,
  output logic                          read_addr_offset,
  output logic                          busy,
  output logic                          swap_done,
  output logic                          err_start
);
  ld_state_e          state, state_nx;
  logic [DRAIN_W-1:0] drain_cnt, drain_cnt_nx;
  logic               clear, swap, last_accept;

  sym_vn_lut_pack u_pack (
    .write_clk       (write_clk),
    .rstn            (rstn),
    .clear           (clear),
    .in_ready        (bus.in_ready),
    .in_valid        (bus.in_valid),
    .in_data         (bus.in_data),
    .we              (bus.we),
    .page_write_addr (bus.page_write_addr),
    .lut_in_bank0    (bus.lut_in_bank0),
    .lut_in_bank1    (bus.lut_in_bank1),
    .last_accept     (last_accept)
  );

  always_comb begin
    state_nx     = state;
    drain_cnt_nx = drain_cnt;
    clear        = 1'b0;
    swap         = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) begin
          state_nx = LOAD;
          clear    = 1'b1;
        end
      end
      LOAD: begin
        if (last_accept) state_nx = ARMED;
      end
      ARMED: begin
        if (iter_boundary) begin
          state_nx     = DRAIN;
          swap         = 1'b1;
          drain_cnt_nx = DRAIN_W'(DRAIN_CYC);
        end
      end
      default: begin
        // Leave DRAIN on the cycle the count reaches zero, so DRAIN lasts exactly DRAIN_CYC cycles.
        if (drain_cnt <= DRAIN_W'(1)) begin
          state_nx     = IDLE;
          drain_cnt_nx = '0;
        end else begin
          drain_cnt_nx = drain_cnt - DRAIN_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge write_clk) begin
    if (!rstn) begin
      state                 <= IDLE;
      drain_cnt             <= '0;
      read_addr_offset      <= 1'b0;
      bus.write_addr_offset <= 1'b1;
      bus.in_ready          <= 1'b0;
      busy                  <= 1'b0;
      swap_done             <= 1'b0;
      err_start             <= 1'b0;
    end else begin
      state     <= state_nx;
      drain_cnt <= drain_cnt_nx;
      if (swap) begin
        read_addr_offset      <= ~read_addr_offset;
        bus.write_addr_offset <= ~bus.write_addr_offset;
      end
      swap_done    <= swap;
      busy         <= (state_nx != IDLE);
      bus.in_ready <= (state_nx == LOAD);
      if (load_start && (state != IDLE)) err_start <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sym_vn_lut_load_ctrl.sv
// Randomized bench for sym_vn_lut_load_ctrl: cycle model of the load/swap rules plus page scoreboard.
module tb_sym_vn_lut_load_ctrl;
  import sym_vn_lut_load_ctrl_pkg::*;

  logic write_clk = 1'b0;
  logic rstn, load_start, iter_boundary;
  logic read_addr_offset, busy, swap_done, err_start;

  sym_vn_lut_load_ctrl_if bus();

  sym_vn_lut_load_ctrl dut (
    .write_clk        (write_clk),
    .rstn             (rstn),
    .load_start       (load_start),
    .iter_boundary    (iter_boundary),
    .bus              (bus),
    .read_addr_offset (read_addr_offset),
    .busy             (busy),
    .swap_done        (swap_done),
    .err_start        (err_start)
  );

  always #5 write_clk = ~write_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stimulus table: entry k of the current load
  logic [QUAN_SIZE-1:0] ent [2*PAGE_NUM];
  // Captured page writes
  logic [QUAN_SIZE-1:0] cap_b0 [PAGE_NUM];
  logic [QUAN_SIZE-1:0] cap_b1 [PAGE_NUM];
  logic                 cap_off [PAGE_NUM];
  int we_cnt = 0;

  typedef enum {M_IDLE, M_LOAD, M_ARMED, M_DRAIN} mphase_e;
  mphase_e m_phase;
  int   m_n, m_left;
  bit   chk_en = 1'b0;
  bit   m_rd, m_err, m_ready, m_busy, m_swap, m_we, m_rst_data;
  int   m_page;
  logic [QUAN_SIZE-1:0] m_b0, m_b1;

  // Compare outputs against last prediction, then predict the outputs after the coming edge.
  always @(negedge write_clk) begin
    bit acc;
    if (chk_en) begin
      check("in_ready", bus.in_ready, m_ready);
      check("we", bus.we, m_we);
      check("busy", busy, m_busy);
      check("swap_done", swap_done, m_swap);
      check("err_start", err_start, m_err);
      check("read_addr_offset", read_addr_offset, m_rd);
      check("write_addr_offset", bus.write_addr_offset, !m_rd);
      if (m_we) begin
        check("page_write_addr", bus.page_write_addr, m_page);
        check("lut_in_bank0", bus.lut_in_bank0, m_b0);
        check("lut_in_bank1", bus.lut_in_bank1, m_b1);
      end
      if (m_rst_data) begin
        check("rst_page", bus.page_write_addr, 0);
        check("rst_bank0", bus.lut_in_bank0, 0);
        check("rst_bank1", bus.lut_in_bank1, 0);
      end
      if (bus.we === 1'b1) begin
        we_cnt++;
        cap_b0[bus.page_write_addr]  = bus.lut_in_bank0;
        cap_b1[bus.page_write_addr]  = bus.lut_in_bank1;
        cap_off[bus.page_write_addr] = bus.write_addr_offset;
      end
    end
    if (!rstn) begin
      chk_en = 1'b1; m_phase = M_IDLE; m_n = 0; m_left = 0;
      m_rd = 0; m_err = 0; m_ready = 0; m_busy = 0; m_swap = 0; m_we = 0; m_rst_data = 1;
    end else begin
      m_rst_data = 0;
      m_swap = 0;
      acc  = bus.in_valid && m_ready;
      m_we = acc && (m_n % 2 == 1);
      if (m_we) begin
        m_page = m_n / 2;
        m_b0   = ent[m_n-1];
        m_b1   = ent[m_n];
      end
      if (load_start && m_phase != M_IDLE) m_err = 1;
      case (m_phase)
        M_IDLE:  if (load_start) begin m_phase = M_LOAD; m_n = 0; end
        M_LOAD:  if (acc) begin m_n++; if (m_n == 2*PAGE_NUM) m_phase = M_ARMED; end
        M_ARMED: if (iter_boundary) begin m_rd = !m_rd; m_swap = 1; m_phase = M_DRAIN; m_left = DRAIN_CYC; end
        M_DRAIN: begin m_left--; if (m_left == 0) m_phase = M_IDLE; end
      endcase
      m_ready = (m_phase == M_LOAD);
      m_busy  = (m_phase != M_IDLE);
    end
  end

  task automatic tick();
    @(posedge write_clk);
    #2;
  endtask

  // gap_mode: 0 back-to-back, 1 alternate valid, 2 random valid + random stray boundaries
  task automatic do_load(input int gap_mode, input int inject_at, input int abort_at);
    int k, cyc;
    bit v, acc;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    k = 0; cyc = 0;
    while (k < 2*PAGE_NUM && cyc < 2000) begin
      if (abort_at == k) begin
        bus.in_valid = 1'b0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        return;
      end
      v = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
      bus.in_valid  = v;
      bus.in_data   = v ? ent[k] : QUAN_SIZE'($urandom);
      load_start    = (cyc == inject_at);
      iter_boundary = (gap_mode == 2) && ($urandom_range(0, 7) == 0);
      acc = v && bus.in_ready;
      tick();
      cyc++;
      if (acc) k++;
    end
    bus.in_valid = 1'b0; load_start = 1'b0; iter_boundary = 1'b0;
    if (k < 2*PAGE_NUM) check("load_timeout", k, 2*PAGE_NUM);
  endtask

  task automatic do_swap(input bit exp_rd);
    iter_boundary = 1'b1;
    tick();
    iter_boundary = 1'b0;
    check("swap_pulse", swap_done, 1);
    check("swap_rd_off", read_addr_offset, exp_rd);
    check("swap_wr_off", bus.write_addr_offset, !exp_rd);
    tick();
    check("swap_one_cycle", swap_done, 0);
    check("drain_busy", busy, 1);
    tick();
    check("idle_after_drain", busy, 0);
  endtask

  initial begin
    int base;
    rstn = 1'b0; load_start = 1'b0; iter_boundary = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (3) tick();
    rstn = 1'b1;
    repeat (10) tick();
    check("t1_rd_off", read_addr_offset, 0);
    check("t1_wr_off", bus.write_addr_offset, 1);
    check("t1_we", bus.we, 0);
    check("t1_busy", busy, 0);

    for (int i = 0; i < 2*PAGE_NUM; i++) ent[i] = QUAN_SIZE'(i);
    base = we_cnt;
    do_load(0, -1, -1);
    repeat (2) tick();
    check("t2_we_count", we_cnt - base, 64);
    check("t2_p0_b0", cap_b0[0], 0);
    check("t2_p0_b1", cap_b1[0], 1);
    check("t2_p63_b0", cap_b0[63], 14);
    check("t2_p63_b1", cap_b1[63], 15);
    check("t2_p5_b1", cap_b1[5], 11);
    check("t2_off", cap_off[5], 1);
    check("t2_armed_busy", busy, 1);
    do_swap(1'b1);

    base = we_cnt;
    do_load(1, -1, -1);
    repeat (2) tick();
    check("t3_we_count", we_cnt - base, 64);
    check("t3_p9_b0", cap_b0[9], 2);
    check("t3_off", cap_off[0], 0);
    do_swap(1'b0);

    iter_boundary = 1'b1;
    tick();
    iter_boundary = 1'b0;
    tick();
    check("t5_no_swap", read_addr_offset, 0);
    for (int i = 0; i < 2*PAGE_NUM; i++) ent[i] = QUAN_SIZE'($urandom);
    base = we_cnt;
    do_load(2, 20, -1);
    repeat (2) tick();
    check("t5_err", err_start, 1);
    check("t5_we_count", we_cnt - base, 64);
    do_swap(1'b1);

    do_load(0, -1, 40);
    check("t6_we", bus.we, 0);
    check("t6_rd_off", read_addr_offset, 0);
    check("t6_wr_off", bus.write_addr_offset, 1);
    check("t6_busy", busy, 0);
    check("t6_err_clr", err_start, 0);
    tick();

    for (int i = 0; i < 2*PAGE_NUM; i++) ent[i] = QUAN_SIZE'($urandom);
    base = we_cnt;
    do_load(2, -1, -1);
    repeat (2) tick();
    check("t7_we_count", we_cnt - base, 64);
    check("t7_p0_b0", cap_b0[0], ent[0]);
    check("t7_off", cap_off[0], 1);
    do_swap(1'b1);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
